// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CTRL   = 2'd2;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_OVERRUN   = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_FULL      = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; pointers carry an extra wrap bit so that
// full and empty remain distinguishable when the indices coincide.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately left without reset; the pointers alone
    // define which entries are valid, and a reset on the array costs muxes.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a small receive FIFO, exposed on the single-cycle
// request/valid data bus as DATA / STATUS / CTRL registers.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 6,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rxd,
    input  logic                  req_valid,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid_data,
    output logic                  irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]      sync_q;
    logic            rxd_s;
    rx_state_t       state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;

    logic            push_byte;
    logic            stop_bad;
    logic            fifo_empty;
    logic            fifo_full;
    logic [7:0]      fifo_dout;

    logic [1:0]            reg_sel;
    logic                  rd_req;
    logic                  data_pop;
    logic                  status_rd;
    logic                  flush;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  overrun;
    logic                  frame_err;
    logic                  overrun_set;

    logic unused_bits;
    assign unused_bits = ^{addr[ADDR_WIDTH-1:2], wdata[DATA_WIDTH-1:1]};

    // Synchroniser resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], rxd};
    end
    assign rxd_s = sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RX_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    baud_cnt <= '0;
                    if (!rxd_s) state <= RX_START;
                end
                RX_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rxd_s ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rxd_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        state    <= rxd_s ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxd_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // Stop-bit verdict is decoded combinationally so the FIFO write lands on the sample edge.
    assign push_byte = (state == RX_STOP) && (baud_cnt == BIT_LAST) && rxd_s;
    assign stop_bad  = (state == RX_STOP) && (baud_cnt == BIT_LAST) && !rxd_s;

    assign reg_sel   = addr[1:0];
    assign rd_req    = req_valid && !we;
    assign data_pop  = rd_req && (reg_sel == UART_DATA);
    assign status_rd = rd_req && (reg_sel == UART_STATUS);
    assign flush     = req_valid && we && (reg_sel == UART_CTRL) && wdata[0];

    // A pop on a full FIFO makes room, so the simultaneous push is not an overrun.
    assign overrun_set = push_byte && fifo_full && !data_pop && !flush;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_byte),
        .pop     (data_pop),
        .flush   (flush),
        .din     (shift_reg),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // NOTE: rd_word gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            UART_DATA: begin
                if (!fifo_empty) rd_word = {{(DATA_WIDTH - 8){1'b0}}, fifo_dout};
            end
            UART_STATUS: begin
                rd_word[STAT_NOT_EMPTY] = !fifo_empty;
                rd_word[STAT_OVERRUN]   = overrun;
                rd_word[STAT_FRAME_ERR] = frame_err;
                rd_word[STAT_FULL]      = fifo_full;
            end
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_data <= 1'b0;
            rdata      <= '0;
        end else begin
            valid_data <= req_valid;
            rdata      <= rd_req ? rd_word : '0;
        end
    end

    // Setting beats the read-clear, so an error coinciding with a STATUS read is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (overrun_set)    overrun <= 1'b1;
            else if (status_rd) overrun <= 1'b0;
            if (stop_bad)       frame_err <= 1'b1;
            else if (status_rd) frame_err <= 1'b0;
        end
    end

    assign irq = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Scoreboard bench: serial frames and bus reads are driven from one process, a
// queue-based byte model predicts each response, and a monitor checks them.
module tb_uart_rx_mmio;

    localparam int C = 16;

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        int          due;
        logic [1:0]  addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rxd;
    logic        req_valid;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        valid_data;
    logic        irq;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    logic [7:0] model_q[$];
    bit         m_ov;
    bit         m_fe;

    int   frame_start_cyc;
    int   irq_rise_cyc = -1;
    logic irq_q = 1'b0;

    uart_rx_mmio #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (6),
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rxd        (rxd),
        .req_valid  (req_valid),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .valid_data (valid_data),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response is matched against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (valid_data) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("resp_cycle_off%0d", e.addr), cyc, e.due);
                if (e.chk_data) check($sformatf("rdata_off%0d", e.addr), rdata, e.data);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            check($sformatf("missing_response_off%0d", exp_q[0].addr), 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (irq && !irq_q) irq_rise_cyc = cyc;
        irq_q = irq;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)                m_fe = 1'b1;
        else if (model_q.size() == 4) m_ov = 1'b1;
        else                         model_q.push_back(b);
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit stop_high, input int stop_bits);
        @(negedge clk);
        frame_start_cyc = cyc;
        rxd = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) @(negedge clk);
        end
        rxd = stop_high;
        repeat (C * stop_bits) @(negedge clk);
        rxd = 1'b1;
        repeat (C) @(negedge clk);
        model_rx(b, stop_high);
    endtask

    task automatic issue(input logic w, input logic [1:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        we        = w;
        addr      = {4'b0, a};
        wdata     = d;
        e.addr     = a;
        e.due      = cyc + 1;
        e.chk_data = !w;
        e.data     = '0;
        if (!w) begin
            if (a == 2'd0 && model_q.size() != 0) begin
                e.data = {24'b0, model_q.pop_front()};
            end else if (a == 2'd1) begin
                e.data = {28'b0, model_q.size() == 4, m_fe, m_ov, model_q.size() != 0};
                m_ov = 1'b0;
                m_fe = 1'b0;
            end
        end else if (a == 2'd2 && d[0]) begin
            model_q.delete();
        end
        exp_q.push_back(e);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        req_valid = 1'b0;
        we        = 1'b0;
        addr      = '0;
        wdata     = '0;
    endtask

    task automatic check_irq(input string name);
        check(name, {31'b0, irq}, {31'b0, model_q.size() != 0});
    endtask

    initial begin
        int n;
        int op;
        logic [7:0] fb;

        reset_n = 1'b0;
        rxd = 1'b1;
        req_valid = 1'b0;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        m_ov = 1'b0;
        m_fe = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 32'd0);
        check("reset_valid", {31'b0, valid_data}, 32'd0);
        check("reset_irq", {31'b0, irq}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte with irq timing.
        irq_rise_cyc = -1;
        send_frame(8'hA5, 1'b1, 1);
        check("irq_rise_cycle", irq_rise_cyc, frame_start_cyc + 3 + C / 2 + 9 * C);
        issue(1'b0, 2'd0, '0);
        idle_bus();
        check("irq_after_read", {31'b0, irq}, 32'd0);

        // Overrun: five frames, no reads.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1);
        check_irq("irq_overrun");
        issue(1'b0, 2'd1, '0);
        for (int i = 0; i < 4; i++) issue(1'b0, 2'd0, '0);
        issue(1'b0, 2'd1, '0);
        idle_bus();

        // Framing error with a long break, then recovery.
        send_frame(8'h3C, 1'b0, 20);
        check_irq("irq_frame_err");
        issue(1'b0, 2'd1, '0);
        idle_bus();
        send_frame(8'h7E, 1'b1, 1);
        issue(1'b0, 2'd0, '0);
        idle_bus();

        // Short glitch must not start a frame.
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * C) @(negedge clk);
        issue(1'b0, 2'd1, '0);
        idle_bus();
        check_irq("irq_glitch");
        send_frame(8'h55, 1'b1, 1);
        issue(1'b0, 2'd0, '0);
        idle_bus();

        // Bus edge cases.
        issue(1'b0, 2'd0, '0);
        idle_bus();
        send_frame(8'($urandom), 1'b1, 1);
        send_frame(8'($urandom), 1'b1, 1);
        issue(1'b1, 2'd3, 32'hFFFF_FFFF);
        issue(1'b0, 2'd3, '0);
        issue(1'b0, 2'd1, '0);
        issue(1'b0, 2'd2, '0);
        issue(1'b1, 2'd2, 32'd1);
        issue(1'b0, 2'd1, '0);
        idle_bus();
        check_irq("irq_after_flush");

        // Back-to-back DATA reads see the post-pop state.
        send_frame(8'($urandom), 1'b1, 1);
        send_frame(8'($urandom), 1'b1, 1);
        issue(1'b0, 2'd0, '0);
        issue(1'b0, 2'd0, '0);
        issue(1'b0, 2'd0, '0);
        idle_bus();

        // Randomised frames and register traffic.
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 5);
            repeat (n) send_frame(8'($urandom), 1'b1, 1);
            n = $urandom_range(1, 6);
            repeat (n) begin
                op = $urandom_range(0, 4);
                case (op)
                    0, 1:    issue(1'b0, 2'd0, '0);
                    2:       issue(1'b0, 2'd1, '0);
                    3:       issue(1'b0, 2'($urandom_range(2, 3)), '0);
                    default: issue(1'b1, ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd2, $urandom);
                endcase
            end
            idle_bus();
            check_irq("irq_random");
        end

        // Clear any leftovers so the reset scenario starts from a known state.
        issue(1'b1, 2'd2, 32'd1);
        issue(1'b0, 2'd1, '0);
        idle_bus();

        // Reset in the middle of a frame with a byte queued and a response in flight.
        send_frame(8'h33, 1'b1, 1);
        fb = 8'hF0;
        @(negedge clk);
        rxd = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = fb[i];
            repeat (C) @(negedge clk);
        end
        req_valid = 1'b1;
        we = 1'b0;
        addr = 6'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        addr = '0;
        check("pre_reset_valid", {31'b0, valid_data}, 32'd1);
        check("pre_reset_rdata", rdata, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_rdata", rdata, 32'd0);
        check("mid_reset_valid", {31'b0, valid_data}, 32'd0);
        check("mid_reset_irq", {31'b0, irq}, 32'd0);
        model_q.delete();
        m_ov = 1'b0;
        m_fe = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (C) @(negedge clk);
        send_frame(8'h81, 1'b1, 1);
        issue(1'b0, 2'd0, '0);
        issue(1'b0, 2'd1, '0);
        idle_bus();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_mmio.md
# uart_rx_mmio

Memory-mapped UART receiver on the SoC data bus, alongside the CPU's data memory. It deserialises 8N1 frames from the `rxd` pin and buffers received bytes in a 4-entry FIFO. The CPU reads those bytes and the status flags through the same single-cycle request/valid bus the data memory uses. It also raises `irq` whenever data is waiting.

## Interface
- `DATA_WIDTH`, 32: bus data width.
- `ADDR_WIDTH`, 6: bus address width. Only `addr[1:0]` is decoded.
- `CLKS_PER_BIT`, 16: clock cycles per baud interval. Must be even and at least 4.
- `FIFO_DEPTH`, 4: receive FIFO entries. Must be a power of two.

- `clk` input, 1: sole clock, rising edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `rxd` input, 1: serial input, asynchronous to `clk`. Idles high.
- `req_valid` input, 1: one-cycle bus request strobe.
- `we` input, 1: write enable, qualified by `req_valid`.
- `addr` input, ADDR_WIDTH: register offset.
- `wdata` input, DATA_WIDTH: write data.
- `rdata` output, DATA_WIDTH: read data. Valid while `valid_data` is high.
- `valid_data` output, 1: one-cycle response strobe.
- `irq` output, 1: high while the FIFO is non-empty.

## Operation
- Register map:
  - Offset 0, DATA, read: returns `{24'b0, byte}` and pops the FIFO. When the FIFO is empty it returns 0 and does not pop.
  - Offset 1, STATUS, read: bit0 = not_empty, bit1 = overrun, bit2 = frame_err, bit3 = full, all other bits 0. The read clears overrun and frame_err.
  - Offset 2, CTRL, read/write: bit0 = flush. Writing 1 empties the FIFO. The bit reads back 0.
  - Offset 3: reads return 0. Writes are ignored.
- Every request is acknowledged, including writes to read-only offsets.
- `rxd` passes through a 2-flop synchroniser. All references to `rxd` below mean the synchronised signal.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a low `rxd` moves to START and clears the baud counter.
  - START: after CLKS_PER_BIT/2 cycles, `rxd` is sampled. Low moves to DATA. High is a glitch and returns to IDLE with no flag set.
  - DATA: 8 samples, LSB first, one every CLKS_PER_BIT cycles. Shift-right into the byte register. After bit 7, move to STOP.
  - STOP: after CLKS_PER_BIT cycles, `rxd` is sampled. High pushes the byte and returns to IDLE. Low sets frame_err, discards the byte, and moves to WAIT_HIGH.
  - WAIT_HIGH: stays until `rxd` is high, then moves to IDLE. This prevents a break condition from retriggering the receiver.
- Push when the FIFO is full: the byte is dropped, overrun is set, and FIFO contents are unchanged.
- Push and DATA pop in the same cycle with the FIFO full: both take effect and overrun is not set.
- Flush in the same cycle as a push: the flush wins and the FIFO ends empty.
- Error set in the same cycle as a STATUS read: the read returns the pre-event value and the flag remains set afterwards.
- Asserting `reset_n` low at any point, including mid-frame: FSM goes to IDLE, FIFO empties, flags clear, all outputs go to 0 immediately. The first frame after reset requires a fresh falling edge.

## Timing
- Reset values: `rdata` = 0, `valid_data` = 0, `irq` = 0, FSM = IDLE, synchroniser flops = 1.
- Bus latency:
  - A request at cycle n gives `valid_data` = 1 with `rdata` valid at cycle n+1, registered.
  - A DATA pop takes effect at n+1.
  - A back-to-back request at n+1 is serviced and sees the post-pop state.
- Receive timing: let t be the cycle in which the synchronised `rxd` is first seen low in IDLE.
  - Start-bit check at t+CLKS_PER_BIT/2.
  - Data bit i sampled at t+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled at t+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - The FIFO write, not_empty and `irq` become visible the cycle after the stop sample.
- The synchroniser adds 2 cycles between the pin edge and t.

## Structure
- Package `uart_pkg` holds:
  - the receiver FSM state enum;
  - register offsets `UART_DATA`, `UART_STATUS`, `UART_CTRL`;
  - status bit-index constants.
- Sub-module `sync_fifo`, parameterised by width and depth:
  - interface: push, pop, flush, dout, empty, full;
  - pointers one bit wider than the index, so full and empty are distinguished on wrap-around.
- The FSM, baud counter, synchroniser and bus decode live in `uart_rx_mmio`.

## Test plan
- Receive byte: frame 0xA5 at CLKS_PER_BIT=16 → `irq` rises on the cycle after the stop sample. DATA read → `rdata` = 0x000000A5, then `irq` = 0.
- Overrun: 5 frames 0x01..0x05 with no reads → STATUS = 0xB (not_empty, overrun, full). Four DATA reads return 0x01..0x04. The next STATUS read returns 0x0.
- Frame error: 0x3C frame with the stop bit held low for 20 bit times → STATUS bit2 = 1 and the FIFO stays empty. After `rxd` returns high, a following 0x7E frame is received correctly.
- Glitch: `rxd` pulsed low for 3 cycles → no push and no flags. A subsequent 0x55 frame is received correctly.
- Bus edges:
  - DATA read on an empty FIFO → `rdata` = 0 with `valid_data` = 1.
  - Write to offset 3 is acknowledged with no effect.
  - CTRL flush with 2 bytes queued → not_empty = 0.
- Reset mid-frame: assert `reset_n` low after data bit 3 of 0xF0 → all outputs go to 0 at once. A frame 0x81 after release is received correctly.
